neuron_mac_seq: RTL and testbench

Downstream consumer of the per-neuron weight BRAMs in the ANN datapath. On START it sweeps a shared address over one weight BRAM and one input-activation BRAM (N_INPUTS entries each) and accumulates signed fixed-point products. It then adds the neuron bias, applies ReLU with saturation and presents one 16-bit activation with a DONE pulse. One instance per neuron feeds the next layer's input buffer.

---
 rtl/neuron_mac_seq_if.sv | 27 ++
 rtl/neuron_mac_seq.sv | 129 ++++++++++++
 tb/tb_neuron_mac_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_mac_seq_if.sv
// Handshake and BRAM bus of one neuron MAC sequencer.
// The slave side is the sequencer; the master side is whoever owns START/BIAS
// and the two read-only BRAMs (weights and input activations).
interface neuron_mac_seq_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
);
   logic              START;
   logic [DATA_W-1:0] BIAS;
   logic [ADDR_W-1:0] MEM_ADDR;
   logic              MEM_EN;
   logic [DATA_W-1:0] W_DO;
   logic [DATA_W-1:0] X_DO;
   logic [DATA_W-1:0] Y;
   logic              DONE;
   logic              BUSY;

   modport master (
      output START, BIAS, W_DO, X_DO,
      input  MEM_ADDR, MEM_EN, Y, DONE, BUSY
   );

   modport slave (
      input  START, BIAS, W_DO, X_DO,
      output MEM_ADDR, MEM_EN, Y, DONE, BUSY
   );
endinterface

// File: rtl/neuron_mac_seq.sv
// Single-neuron multiply-accumulate sequencer: sweeps one shared address over
// the weight and input BRAMs, sums signed Q8.8 products into a Q24.16
// accumulator, adds the bias, then applies ReLU with saturation to Q8.8.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for START; MEM_EN low
// S_READ  | address sweep; each edge adds the product of the previous address
// S_FINAL | last product added, bias/ReLU/saturate, DONE pulse
module neuron_mac_seq #(
   parameter int N_INPUTS  = 28,
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 16,
   parameter int FRAC_BITS = 8,
   parameter int ACC_W     = 40
) (
   input logic              CLK,
   input logic              RST,
   neuron_mac_seq_if.slave  bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_FINAL = 2'd2;

   localparam int                      PROD_W    = 2 * DATA_W;
   localparam logic [ADDR_W-1:0]       LAST_ADDR = ADDR_W'(N_INPUTS - 1);
   localparam logic signed [ACC_W-1:0] Y_MAX     = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);

   logic [1:0]               state_q, state_d;
   logic signed [ACC_W-1:0]  acc_q,   acc_d;
   logic [DATA_W-1:0]        bias_q,  bias_d;
   logic [ADDR_W-1:0]        addr_q,  addr_d;
   logic                     en_q,    en_d;
   logic [DATA_W-1:0]        y_q,     y_d;
   logic                     done_q,  done_d;

   logic signed [PROD_W-1:0] w_ext, x_ext, prod;
   logic signed [ACC_W-1:0]  prod_ext, acc_sum, acc_shr, bias_ext, s_val;

   // Product of the current BRAM read data and the running sum including it.
   always_comb begin
      w_ext    = {{DATA_W{bus.W_DO[DATA_W-1]}}, bus.W_DO};
      x_ext    = {{DATA_W{bus.X_DO[DATA_W-1]}}, bus.X_DO};
      prod     = w_ext * x_ext;
      prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
      acc_sum  = acc_q + prod_ext;
      acc_shr  = acc_sum >>> FRAC_BITS;
      bias_ext = {{(ACC_W - DATA_W){bias_q[DATA_W-1]}}, bias_q};
      s_val    = acc_shr + bias_ext;
   end

   // Sequencer next-state logic. The edge that sees the last address in READ
   // only closes the BRAM; the last product (still held on the BRAM output
   // because MEM_EN is low) is added in FINAL together with bias and clamp.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      bias_d  = bias_q;
      addr_d  = addr_q;
      en_d    = en_q;
      y_d     = y_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.START) begin
               acc_d   = '0;
               bias_d  = bus.BIAS;
               addr_d  = '0;
               en_d    = 1'b1;
               state_d = S_READ;
            end
         end
         S_READ: begin
            if (addr_q == LAST_ADDR) begin
               en_d    = 1'b0;
               state_d = S_FINAL;
            end else begin
               acc_d  = acc_sum;
               addr_d = addr_q + 1'b1;
            end
         end
         S_FINAL: begin
            acc_d = acc_sum;
            if (s_val < 0) begin
               y_d = '0;
            end else if (s_val > Y_MAX) begin
               y_d = Y_MAX[DATA_W-1:0];
            end else begin
               y_d = s_val[DATA_W-1:0];
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            en_d    = 1'b0;
         end
      endcase
   end

   // State registers with synchronous reset; an interrupted sweep is dropped.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         bias_q  <= '0;
         addr_q  <= '0;
         en_q    <= 1'b0;
         y_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         bias_q  <= bias_d;
         addr_q  <= addr_d;
         en_q    <= en_d;
         y_q     <= y_d;
         done_q  <= done_d;
      end
   end

   assign bus.MEM_ADDR = addr_q;
   assign bus.MEM_EN   = en_q;
   assign bus.Y        = y_q;
   assign bus.DONE     = done_q;
   assign bus.BUSY     = (state_q != S_IDLE);

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Bench for neuron_mac_seq: negedge-read BRAM model, dot-product reference
// model, per-cycle compare process, directed cases and randomized windows.
module tb_neuron_mac_seq;
   localparam int N = 28;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   neuron_mac_seq_if #(.ADDR_W(5), .DATA_W(16)) bus ();

   neuron_mac_seq #(
      .N_INPUTS(N), .ADDR_W(5), .DATA_W(16), .FRAC_BITS(8), .ACC_W(40)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
   );

   logic signed [15:0] w_mem [N];
   logic signed [15:0] x_mem [N];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: plain dot product, floor shift, bias, ReLU, saturate.
   function automatic logic [15:0] model_y(input logic [15:0] b);
      longint acc = 0;
      longint s;
      for (int i = 0; i < N; i++) acc += longint'(w_mem[i]) * longint'(x_mem[i]);
      s = (acc >>> 8) + longint'($signed(b));
      if (s < 0) return 16'h0000;
      if (s > 64'sd32767) return 16'h7FFF;
      return s[15:0];
   endfunction

   // BRAM model: registered read on negedge, output held while disabled.
   always @(negedge clk) begin
      if (bus.MEM_EN && int'(bus.MEM_ADDR) < N) begin
         bus.W_DO = w_mem[bus.MEM_ADDR];
         bus.X_DO = x_mem[bus.MEM_ADDR];
      end
   end

   // Timing model: phase counts edges since the accepting edge E0.
   int          phase    = -1;
   logic [15:0] y_exp    = '0;
   logic [15:0] pend     = '0;
   logic        done_exp = 1'b0;

   always @(posedge clk) begin
      done_exp = 1'b0;
      if (rst) begin
         phase = -1;
         y_exp = '0;
      end else if (phase < 0) begin
         if (bus.START) begin
            phase = 0;
            pend  = model_y(bus.BIAS);
         end
      end else begin
         phase++;
         if (phase == N + 1) begin
            y_exp    = pend;
            done_exp = 1'b1;
            phase    = -1;
         end
      end
      #1;
      check("done", int'(bus.DONE), int'(done_exp));
      check("y", int'(bus.Y), int'(y_exp));
      check("busy", int'(bus.BUSY), int'(phase >= 0));
      check("mem_en", int'(bus.MEM_EN), int'(phase >= 0 && phase < N));
      if (phase >= 0) check("mem_addr", int'(bus.MEM_ADDR), (phase < N) ? phase : N - 1);
   end

   task automatic fill(input logic [15:0] wv, input logic [15:0] xv);
      for (int i = 0; i < N; i++) begin
         w_mem[i] = wv;
         x_mem[i] = xv;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40 && bus.BUSY; i++) begin
         @(posedge clk);
         #1;
      end
      check("idle_timeout", int'(bus.BUSY), 0);
   endtask

   task automatic run_fixed(input string nm, input logic [15:0] wv, input logic [15:0] xv,
                            input logic [15:0] b, input logic [15:0] exp);
      int lat;
      int en_cnt;
      @(negedge clk);
      fill(wv, xv);
      bus.BIAS = b;
      check({nm, "_model_pin"}, int'(model_y(b)), int'(exp));
      bus.START = 1'b1;
      @(posedge clk);
      #1;
      bus.START = 1'b0;
      en_cnt = int'(bus.MEM_EN);
      lat = 0;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if (bus.DONE) begin
            lat = i;
            break;
         end
         en_cnt += int'(bus.MEM_EN);
      end
      check({nm, "_latency"}, lat, 29);
      check({nm, "_y"}, int'(bus.Y), int'(exp));
      check({nm, "_en_cycles"}, en_cnt, 28);
   endtask

   initial begin
      int lat;
      int d0;
      int d1;
      logic [15:0] yv;
      bus.START = 1'b0;
      bus.BIAS  = '0;
      fill(16'h0, 16'h0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", int'(bus.BUSY), 0);
      check("rst_en", int'(bus.MEM_EN), 0);
      check("rst_y", int'(bus.Y), 0);
      check("rst_done", int'(bus.DONE), 0);
      check("rst_addr", int'(bus.MEM_ADDR), 0);
      @(negedge clk);
      rst = 1'b0;

      run_fixed("unity", 16'h0100, 16'h0100, 16'h0000, 16'h1C00);
      run_fixed("relu",  16'hFF00, 16'h0100, 16'h0080, 16'h0000);
      run_fixed("sat",   16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
      run_fixed("trunc", 16'h0001, 16'h0001, 16'h0000, 16'h0000);
      run_fixed("small", 16'h0010, 16'h0010, 16'h0000, 16'h001C);

      // Reset in the middle of a sweep.
      @(negedge clk);
      fill(16'h0100, 16'h0100);
      bus.BIAS  = 16'h0;
      bus.START = 1'b1;
      @(posedge clk);
      #1;
      bus.START = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_busy", int'(bus.BUSY), 0);
      check("midrst_en", int'(bus.MEM_EN), 0);
      check("midrst_y", int'(bus.Y), 0);
      @(negedge clk);
      rst = 1'b0;
      d0 = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         d0 += int'(bus.DONE);
      end
      check("midrst_no_done", d0, 0);
      run_fixed("after_rst", 16'h0100, 16'h0100, 16'h0000, 16'h1C00);

      // START pulses and BIAS churn while busy.
      @(negedge clk);
      bus.BIAS  = 16'h0;
      bus.START = 1'b1;
      @(posedge clk);
      #1;
      bus.START = 1'b0;
      lat = 0;
      yv  = '0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.DONE && lat == 0) begin
            lat = i;
            yv  = bus.Y;
         end
         bus.START = (i == 5 || i == 12);
         bus.BIAS  = 16'($urandom);
      end
      bus.START = 1'b0;
      check("busy_start_latency", lat, 29);
      check("busy_bias_y", int'(yv), 16'h1C00);

      // Back-to-back with START held high.
      wait_idle();
      for (int i = 0; i < N; i++) begin
         w_mem[i] = 16'($urandom_range(0, 1023)) - 16'sd512;
         x_mem[i] = 16'($urandom_range(0, 1023)) - 16'sd512;
      end
      bus.BIAS  = 16'h0040;
      bus.START = 1'b1;
      d0 = -1;
      d1 = -1;
      for (int i = 0; i < 100 && d1 < 0; i++) begin
         @(posedge clk);
         #1;
         if (bus.DONE) begin
            if (d0 < 0) d0 = i;
            else d1 = i;
         end
      end
      bus.START = 1'b0;
      check("b2b_period", d1 - d0, 30);
      wait_idle();

      // Randomized windows; memories change only while idle.
      for (int w = 0; w < 14; w++) begin
         int mode;
         mode = int'($urandom_range(0, 2));
         for (int i = 0; i < N; i++) begin
            case (mode)
               0:       begin w_mem[i] = 16'($urandom); x_mem[i] = 16'($urandom); end
               1:       begin
                  w_mem[i] = 16'($urandom_range(0, 1023)) - 16'sd512;
                  x_mem[i] = 16'($urandom_range(0, 1023)) - 16'sd512;
               end
               default: begin
                  w_mem[i] = 16'($urandom_range(0, 1024));
                  x_mem[i] = 16'($urandom_range(0, 512));
               end
            endcase
         end
         for (int c = 0; c < 90; c++) begin
            @(posedge clk);
            #1;
            bus.START = ($urandom_range(0, 3) == 0);
            bus.BIAS  = 16'($urandom_range(0, 1023)) - 16'sd512;
         end
         bus.START = 1'b0;
         wait_idle();
      end

      repeat (2) @(posedge clk);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
